// File: rtl/sd_dac_pkg.sv
// Shared constants and saturating arithmetic for the second-order sigma-delta DAC.
package sd_dac_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int ACC_W_DEF = 24;
    localparam int FS        = 1 << (IN_W_DEF - 1);

    // Arithmetic is done at a fixed wide width so one function serves any ACC_W.
    localparam int SAT_W = 64;
    localparam logic signed [SAT_W+1:0] SAT_ONE = {{(SAT_W+1){1'b0}}, 1'b1};

    // acc + add - sub, clamped to the signed range of a w-bit register.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] add,
        input logic signed [SAT_W-1:0] sub,
        input int unsigned             w
    );
        logic signed [SAT_W+1:0] sum;
        logic signed [SAT_W+1:0] hi;
        logic signed [SAT_W+1:0] lo;
        sum = {{2{acc[SAT_W-1]}}, acc} + {{2{add[SAT_W-1]}}, add} - {{2{sub[SAT_W-1]}}, sub};
        hi  = (SAT_ONE <<< (w - 32'd1)) - SAT_ONE;
        lo  = -(SAT_ONE <<< (w - 32'd1));
        if (sum > hi) begin
            sat_add = SAT_W'(hi);
        end else if (sum < lo) begin
            sat_add = SAT_W'(lo);
        end else begin
            sat_add = SAT_W'(sum);
        end
    endfunction

endpackage

// File: rtl/sd_integ.sv
// Saturating accumulator: acc <= sat(acc + a - b). The next value is exported
// combinationally so a following stage can use it in the same cycle.
module sd_integ
    import sd_dac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    clr_i,
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W-1:0] b_i,
    output logic signed [ACC_W-1:0] d_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    // Next accumulator value, clamped so the integrator never wraps.
    always_comb begin
        acc_d = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(a_i), SAT_W'(b_i), ACC_W));
        d_o   = acc_d;
    end

    // Accumulator register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sd_dac.sv
// Second-order 1-bit sigma-delta DAC modulator, NTF (1 - z^-1)^2.
// Two cascaded saturating integrators, feedback mux and sign comparator.
module sd_dac
    import sd_dac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] sig,
    output logic                   dac_out
);

    localparam logic signed [ACC_W-1:0] FB_POS =
        {{(ACC_W-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] FB_NEG = -FB_POS;

    logic                    dac_q;
    logic                    dac_d;
    logic signed [ACC_W-1:0] sig_ext_s;
    logic signed [ACC_W-1:0] fb_s;
    logic signed [ACC_W-1:0] i1_d_s;
    logic signed [ACC_W-1:0] i2_d_s;

    // Sign extension, feedback from the registered bit, and quantizer on i2's next value.
    always_comb begin
        sig_ext_s = {{(ACC_W-IN_W){sig[IN_W-1]}}, sig};
        if (dac_q) begin
            fb_s = FB_POS;
        end else begin
            fb_s = FB_NEG;
        end
        dac_d = ~i2_d_s[ACC_W-1];
    end

    sd_integ #(.ACC_W(ACC_W)) u_integ1 (
        .clk_i (clk),
        .clr_i (rst),
        .a_i   (sig_ext_s),
        .b_i   (fb_s),
        .d_o   (i1_d_s)
    );

    // Delay-free cascade: the second stage consumes i1's freshly computed value.
    sd_integ #(.ACC_W(ACC_W)) u_integ2 (
        .clk_i (clk),
        .clr_i (rst),
        .a_i   (i1_d_s),
        .b_i   (fb_s),
        .d_o   (i2_d_s)
    );

    // Output bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_q <= 1'b0;
        end else begin
            dac_q <= dac_d;
        end
    end

    assign dac_out = dac_q;

endmodule

// File: tb/tb_sd_dac.sv
// Scoreboard bench for sd_dac: random and directed stimulus against an integer reference model.
module tb_sd_dac;
    import sd_dac_pkg::*;

    localparam int     ACC_W = ACC_W_DEF;
    localparam longint A_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam longint A_MIN = -(64'sd1 <<< (ACC_W - 1));

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic signed [IN_W_DEF-1:0]     sig = '0;
    logic                           dac_out;

    sd_dac #(.IN_W(IN_W_DEF), .ACC_W(ACC_W_DEF)) dut (
        .clk     (clk),
        .rst     (rst),
        .sig     (sig),
        .dac_out (dac_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     d;
        longint i1;
        longint i2;
    } exp_t;

    exp_t   exp_q[$];
    int     dac_log[$];
    int     sig_log[$];
    int     issued = 0;
    int     checks = 0;
    int     errors = 0;
    longint m_i1 = 0;
    longint m_i2 = 0;
    bit     m_d  = 1'b0;
    exp_t   mon_e;
    longint mon_i1;
    longint mon_i2;

    function automatic longint clamp(input longint v);
        if (v > A_MAX) return A_MAX;
        if (v < A_MIN) return A_MIN;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Drive one sample before the next rising edge and queue the model's post-edge state.
    task automatic step(input int s, input bit r);
        longint fb;
        @(negedge clk);
        sig = IN_W_DEF'(s);
        rst = r;
        if (r) begin
            m_i1 = 0;
            m_i2 = 0;
            m_d  = 1'b0;
        end else begin
            fb   = m_d ? longint'(FS) : -longint'(FS);
            m_i1 = clamp(m_i1 + s - fb);
            m_i2 = clamp(m_i2 + m_i1 - fb);
            m_d  = (m_i2 >= 0);
        end
        exp_q.push_back('{m_d, m_i1, m_i2});
        issued++;
    endtask

    task automatic chk_state(input string name, input longint d, input longint i1, input longint i2);
        @(posedge clk);
        #1;
        check({name, "_dac"}, longint'(dac_out), d);
        check({name, "_i1"}, longint'(dut.u_integ1.acc_q), i1);
        check({name, "_i2"}, longint'(dut.u_integ2.acc_q), i2);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    function automatic int count_ones(input int start, input int len);
        int c;
        c = 0;
        for (int k = 0; k < len; k++) c += dac_log[start + k];
        return c;
    endfunction

    // Monitor: every output cycle is compared against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e  = exp_q.pop_front();
                mon_i1 = longint'(dut.u_integ1.acc_q);
                mon_i2 = longint'(dut.u_integ2.acc_q);
                checks++;
                if (dac_out !== mon_e.d || mon_i1 != mon_e.i1 || mon_i2 != mon_e.i2) begin
                    errors++;
                    $display("FAIL cycle%0d: dac/i1/i2 got %0b/%0d/%0d, expected %0b/%0d/%0d",
                             dac_log.size(), dac_out, mon_i1, mon_i2, mon_e.d, mon_e.i1, mon_e.i2);
                end
                dac_log.push_back((dac_out === 1'b1) ? 1 : 0);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int    base;
        int    base2;
        int    s0;
        int    fa;
        int    fbi;
        int    mism;
        int    rv;
        int    zd[4];
        int    zi1[4];
        int    zi2[4];
        real   acc;
        real   err;
        real   sumsq;
        real   rms;

        zd  = '{1, 1, 0, 1};
        zi1 = '{32768, 0, -32768, 0};
        zi2 = '{65536, 32768, -32768, 0};

        // Reset held three edges with a nonzero sample.
        for (int k = 0; k < 3; k++) begin
            step(1234, 1'b1);
            chk_state("reset", 0, 0, 0);
        end

        // Zero input from reset: known first four states, then half density.
        base = issued;
        for (int k = 0; k < 4; k++) begin
            step(0, 1'b0);
            chk_state($sformatf("zero_e%0d", k + 1), zd[k], zi1[k], zi2[k]);
        end
        for (int k = 4; k < 4096; k++) step(0, 1'b0);
        drain();
        check_range("zero_density", count_ones(base, 4096), 2046, 2050);

        // Random samples within the stable range.
        for (int k = 0; k < 3000; k++) begin
            rv = int'($urandom_range(58980)) - 29490;
            step(rv, 1'b0);
        end

        // DC levels.
        for (int k = 0; k < 100; k++) step(16384, 1'b0);
        base = issued;
        for (int k = 0; k < 8192; k++) step(16384, 1'b0);
        drain();
        check_range("dc_pos_density", count_ones(base, 8192), 6140, 6148);

        for (int k = 0; k < 100; k++) step(-30000, 1'b0);
        base = issued;
        for (int k = 0; k < 8192; k++) step(-30000, 1'b0);
        drain();
        check_range("dc_neg_density", count_ones(base, 8192), 330, 362);

        // Negative full scale drives the integrators into clamp, then recovery.
        for (int k = 0; k < 10000; k++) step(-32768, 1'b0);
        for (int k = 0; k < 2000; k++) step(0, 1'b0);
        base2 = issued;
        for (int k = 0; k < 4096; k++) step(0, 1'b0);
        drain();
        check_range("sat_recovery_density", count_ones(base2, 4096), 2008, 2088);

        // Slow sine: moving-average tracking and overall density.
        s0 = issued;
        for (int n = 0; n < 21000; n++) begin
            rv = int'(10000.0 * $sin(2.0 * 3.14159265358979 * 0.001 * n));
            sig_log.push_back(rv);
            step(rv, 1'b0);
        end
        drain();
        check_range("sine_density", count_ones(s0 + 1000, 20000), 9980, 10020);
        sumsq = 0.0;
        for (int n = 1000; n < 21000; n++) begin
            acc = 0.0;
            for (int k = 0; k < 64; k++) acc += (dac_log[s0 + n - k] != 0) ? 32768.0 : -32768.0;
            err   = acc / 64.0 - sig_log[n - 32];
            sumsq += err * err;
        end
        rms = $sqrt(sumsq / 20000.0);
        check_range("sine_rms", longint'(rms), 0, 599);

        // Mid-run reset reproduces a fresh run.
        step(16384, 1'b1);
        fa = issued;
        for (int k = 0; k < 499; k++) step(16384, 1'b0);
        step(16384, 1'b1);
        chk_state("midrun_reset", 0, 0, 0);
        fbi = issued;
        for (int k = 0; k < 200; k++) step(16384, 1'b0);
        drain();
        mism = 0;
        for (int k = 0; k < 200; k++) if (dac_log[fa + k] != dac_log[fbi + k]) mism++;
        check("midrun_repeat_mismatches", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
